// File: rtl/tone_freq_meter.sv
// Tone frequency meter: counts synchronized rising edges of tone_in between
// gate_tick pulses and publishes the count with overflow and tolerance flags.
module tone_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 2
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             gate_tick,
  input  logic             tone_in,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow,
  output logic             in_tol
);

  localparam int                SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W:0]    TOL_W   = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]    ONE_W   = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  logic [SS-1:0]    sync_q, sync_d;
  logic             dly_q, dly_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             in_tol_q, in_tol_d;

  logic             edge_now;
  logic [CNT_W:0]   sum_ext;
  logic             sat_now;
  logic [CNT_W-1:0] sum_sat;
  logic             ovf_pub;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   abs_diff;

  // Synchronizer shift chain: stage 0 captures the asynchronous tone.
  assign sync_d[0] = tone_in;
  generate
    for (genvar gi = 1; gi < SS; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  always_comb begin
    dly_d    = sync_q[SS-1];
    edge_now = sync_q[SS-1] & ~dly_q;
  end

  // One adder serves both in-window counting and the closing-edge publish.
  always_comb begin
    sum_ext  = {1'b0, count_q} + {{CNT_W{1'b0}}, edge_now};
    sat_now  = sum_ext[CNT_W];
    sum_sat  = sat_now ? CNT_MAX : sum_ext[CNT_W-1:0];
    ovf_pub  = sticky_q | sat_now;
    // Two's-complement difference in CNT_W+1 bits, then magnitude.
    diff     = {1'b0, sum_sat} - {1'b0, target};
    abs_diff = diff[CNT_W] ? (~diff + ONE_W) : diff;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sticky_d   = sticky_q;
    freq_d     = freq_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;
    in_tol_d   = in_tol_q;

    if (!enable) begin
      state_d  = IDLE;
      count_d  = '0;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d  = '0;
          sticky_d = 1'b0;
          if (gate_tick) begin
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (gate_tick) begin
            freq_d     = sum_sat;
            overflow_d = ovf_pub;
            in_tol_d   = (abs_diff <= TOL_W) && !ovf_pub;
            valid_d    = 1'b1;
            count_d    = '0;
            sticky_d   = 1'b0;
          end else begin
            count_d  = sum_sat;
            sticky_d = sticky_q | sat_now;
          end
        end
        default: begin
          state_d  = IDLE;
          count_d  = '0;
          sticky_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      sync_q     <= '0;
      dly_q      <= 1'b0;
      state_q    <= IDLE;
      count_q    <= '0;
      sticky_q   <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      in_tol_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      dly_q      <= dly_d;
      state_q    <= state_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      in_tol_q   <= in_tol_d;
    end
  end

  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign in_tol   = in_tol_q;

endmodule

// File: tb/tb_tone_freq_meter.sv
// Directed bench for tone_freq_meter: a default-width instance plus an 8-bit
// instance sharing the same stimulus so saturation is reachable quickly.
module tb_tone_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        gate_tick;
  logic        tone_in;
  logic [15:0] target;
  logic [7:0]  target_s;
  logic [15:0] freq;
  logic        valid, overflow, in_tol;
  logic [7:0]  freq_s;
  logic        valid_s, overflow_s, in_tol_s;

  logic tone_auto = 1'b1;
  logic tone_gen  = 1'b0;
  logic tone_man  = 1'b0;
  int   tone_per  = 4;
  int   ph        = 0;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int vsnap;

  initial forever #5 clk = ~clk;

  assign tone_in = tone_auto ? tone_gen : tone_man;

  always @(negedge clk) begin
    if (ph >= tone_per - 1) ph <= 0;
    else ph <= ph + 1;
    tone_gen <= (ph < tone_per / 2);
  end

  always @(negedge clk) if (valid) vcount <= vcount + 1;

  tone_freq_meter u_dut (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .gate_tick(gate_tick),
    .tone_in  (tone_in),
    .target   (target),
    .freq     (freq),
    .valid    (valid),
    .overflow (overflow),
    .in_tol   (in_tol)
  );

  tone_freq_meter #(.CNT_W(8)) u_small (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .gate_tick(gate_tick),
    .tone_in  (tone_in),
    .target   (target_s),
    .freq     (freq_s),
    .valid    (valid_s),
    .overflow (overflow_s),
    .in_tol   (in_tol_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic gate_window(input int n);
    repeat (n - 1) @(negedge clk);
    gate_tick = 1'b1;
    @(negedge clk);
    gate_tick = 1'b0;
  endtask

  task automatic chk_pub(input string tag, input int f, input bit o, input bit t);
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".freq"}, 32'(freq), 32'(f));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
    chk({tag, ".in_tol"}, 32'(in_tol), 32'(t));
    $display("publish %s: freq=%0d overflow=%0d in_tol=%0d", tag, freq, overflow, in_tol);
  endtask

  task automatic chk_pub_s(input string tag, input int f, input bit o, input bit t);
    chk({tag, ".s_valid"}, 32'(valid_s), 32'd1);
    chk({tag, ".s_freq"}, 32'(freq_s), 32'(f));
    chk({tag, ".s_overflow"}, 32'(overflow_s), 32'(o));
    chk({tag, ".s_in_tol"}, 32'(in_tol_s), 32'(t));
    $display("publish8 %s: freq=%0d overflow=%0d in_tol=%0d", tag, freq_s, overflow_s, in_tol_s);
  endtask

  task automatic chk_valid_low(input string tag);
    @(negedge clk);
    chk({tag, ".valid_low"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    gate_tick = 1'b0;
    target    = 16'd100;
    target_s  = 8'd100;
    repeat (5) @(negedge clk);
    chk("rst.freq", 32'(freq), 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.in_tol", 32'(in_tol), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Arming tick produces no publish.
    enable = 1'b1;
    gate_window(50);
    @(negedge clk);
    chk("arm.no_valid", 32'(vcount), 32'd0);

    gate_window(400);
    chk_pub("nominal", 100, 1'b0, 1'b1);
    chk_pub_s("nominal", 100, 1'b0, 1'b1);
    chk_valid_low("nominal");
    gate_window(399);
    chk_pub("nominal2", 100, 1'b0, 1'b1);
    chk_valid_low("nominal2");
    chk("nominal.pulses", 32'(vcount), 32'd2);

    // Tolerance boundaries around 100 with TOL=2.
    target = 16'd97;
    gate_window(400);
    chk_pub("tgt97", 100, 1'b0, 1'b0);
    target = 16'd103;
    gate_window(400);
    chk_pub("tgt103", 100, 1'b0, 1'b0);
    target = 16'd98;
    gate_window(400);
    chk_pub("tgt98", 100, 1'b0, 1'b1);
    target = 16'd102;
    gate_window(400);
    chk_pub("tgt102", 100, 1'b0, 1'b1);

    // Saturation on the 8-bit instance with a 2-cycle tone.
    tone_per = 2;
    target   = 16'd100;
    target_s = 8'd255;
    gate_window(400);
    gate_window(510);
    chk_pub("edges255", 255, 1'b0, 1'b0);
    chk_pub_s("edges255", 255, 1'b0, 1'b1);
    gate_window(512);
    chk_pub("edges256", 256, 1'b0, 1'b0);
    chk_pub_s("edges256", 255, 1'b1, 1'b0);
    gate_window(600);
    chk_pub_s("edges300", 255, 1'b1, 1'b0);
    tone_per = 4;
    target_s = 8'd100;
    gate_window(400);
    gate_window(400);
    chk_pub_s("after_ovf", 100, 1'b0, 1'b1);
    chk_valid_low("after_ovf");

    // Manual edges, last one landing on the gate_tick cycle.
    tone_auto = 1'b0;
    tone_man  = 1'b0;
    target    = 16'd4;
    gate_window(20);
    repeat (3) begin
      tone_man = 1'b1; repeat (3) @(negedge clk);
      tone_man = 1'b0; repeat (3) @(negedge clk);
    end
    tone_man = 1'b1;
    repeat (2) @(negedge clk);
    gate_tick = 1'b1;
    @(negedge clk);
    gate_tick = 1'b0;
    chk_pub("edge_on_tick", 4, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tone_man = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2) begin
      tone_man = 1'b1; repeat (3) @(negedge clk);
      tone_man = 1'b0; repeat (3) @(negedge clk);
    end
    gate_window(5);
    chk_pub("after_tick_edge", 2, 1'b0, 1'b1);
    chk_valid_low("after_tick_edge");

    // Back-to-back ticks; target changes between them.
    vsnap  = vcount;
    target = 16'd1;
    gate_tick = 1'b1;
    @(negedge clk);
    target = 16'd3;
    chk_pub("b2b_first", 0, 1'b0, 1'b1);
    @(negedge clk);
    gate_tick = 1'b0;
    chk_pub("b2b_second", 0, 1'b0, 1'b0);
    chk_valid_low("b2b");
    chk("b2b.pulses", 32'(vcount - vsnap), 32'd2);

    // Reset mid-window.
    tone_auto = 1'b1;
    tone_per  = 4;
    target    = 16'd100;
    gate_window(400);
    gate_window(400);
    chk_pub("pre_reset", 100, 1'b0, 1'b1);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.freq", 32'(freq), 32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    chk("midrst.overflow", 32'(overflow), 32'd0);
    chk("midrst.in_tol", 32'(in_tol), 32'd0);
    vsnap = vcount;
    gate_window(200);
    @(negedge clk);
    chk("midrst.rearm_no_valid", 32'(vcount - vsnap), 32'd0);
    gate_window(399);
    chk_pub("post_reset", 100, 1'b0, 1'b1);
    chk_valid_low("post_reset");

    // Enable dropped mid-window, a tick while disabled, then re-arm.
    tone_per = 2;
    repeat (100) @(negedge clk);
    vsnap  = vcount;
    enable = 1'b0;
    repeat (50) @(negedge clk);
    gate_tick = 1'b1;
    @(negedge clk);
    gate_tick = 1'b0;
    repeat (50) @(negedge clk);
    chk("disabled.freq_hold", 32'(freq), 32'd100);
    chk("disabled.no_valid", 32'(vcount - vsnap), 32'd0);
    enable = 1'b1;
    gate_window(50);
    @(negedge clk);
    chk("rearm.no_valid", 32'(vcount - vsnap), 32'd0);
    chk("rearm.freq_hold", 32'(freq), 32'd100);
    gate_window(399);
    chk_pub("reenabled", 200, 1'b0, 1'b0);
    chk_valid_low("reenabled");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
